intersection_arbiter: RTL and testbench

- Phase scheduler for a two-road intersection with a pedestrian crossing; the intersection is the shared resource.
- Three requesters: road 1 sensor, road 2 sensor and a latched pedestrian button.
- Grants green to one requester at a time with round-robin fairness, minimum/maximum green limits, and yellow plus all-red clearance between grants.
- Drives the lamp encodings directly; the top-level instantiates it in place of the simple two-road sequencer.

---
 rtl/intersection_arbiter.sv | 157 +++++++++++++++
 tb/tb_intersection_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_arbiter.sv
// intersection_arbiter
//   Phase scheduler for a two-road intersection with a pedestrian crossing.
//   Three requesters (road 1 sensor, road 2 sensor, latched ped button) get
//   green one at a time, round-robin, with min/max green limits and
//   yellow + all-red clearance between grants.
//
//   Optional macro: NIGHT_FLASH_EN adds the night flashing-yellow mode.
//
// Ports:
//   clock        system clock, rising edge
//   reset_       asynchronous active-low reset
//   sens1/sens2  vehicle present on road 1 / road 2
//   ped_btn      pedestrian button, sampled each clock into a latch
//   night        night flash request (only with NIGHT_FLASH_EN)
//   via1/via2    lamp codes: ROSSO=0, GIALLO=1, VERDE=2
//   walk         pedestrian walk lamp
//   ped_pending  pedestrian latch state
//   phase        CLR=0 G1=1 Y1=2 G2=3 Y2=4 WALK=5 FLASH=6
module intersection_arbiter #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1,
    parameter int WALK      = 6,
    parameter int CNT_W     = 4
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       sens1,
    input  logic       sens2,
    input  logic       ped_btn,
    input  logic       night,
    output logic [1:0] via1,
    output logic [1:0] via2,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_CLR = 3'd0, S_G1 = 3'd1, S_Y1 = 3'd2, S_G2 = 3'd3,
        S_Y2 = 3'd4, S_WALK = 3'd5, S_FLASH = 3'd6
    } state_t;

    localparam logic [1:0] ROSSO  = 2'd0;
    localparam logic [1:0] GIALLO = 2'd1;
    localparam logic [1:0] VERDE  = 2'd2;

    localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] RED_M1  = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] elapsed;
    logic [1:0]       ptr, ptr_nx;      // 0=road1, 1=road2, 2=ped
    logic [1:0]       arb_sel;
    logic             ped_req, any_req, night_req, ped_nx;

`ifdef NIGHT_FLASH_EN
    assign night_req = night;
`else
    logic unused_night;
    assign unused_night = night;
    assign night_req    = 1'b0;
`endif

    // A press on the decision edge itself counts at that edge.
    assign ped_req = ped_pending | ped_btn;
    assign any_req = sens1 | sens2 | ped_req;
    assign phase   = state;

    // Round-robin scan starting at ptr: road1 -> road2 -> ped -> road1.
    always_comb begin
        arb_sel = 2'd0;
        case (ptr)
            2'd1:    arb_sel = sens2   ? 2'd1 : (ped_req ? 2'd2 : 2'd0);
            2'd2:    arb_sel = ped_req ? 2'd2 : (sens1   ? 2'd0 : 2'd1);
            default: arb_sel = sens1   ? 2'd0 : (sens2   ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            S_CLR: if (elapsed == RED_M1) begin
                if (night_req) begin
                    state_nx = S_FLASH;
                end else if (!any_req) begin
                    state_nx = S_G1;   // idle rest on road 1, ptr untouched
                end else begin
                    case (arb_sel)
                        2'd0:    state_nx = S_G1;
                        2'd1:    state_nx = S_G2;
                        default: state_nx = S_WALK;
                    endcase
                    ptr_nx = (arb_sel == 2'd2) ? 2'd0 : arb_sel + 2'd1;
                end
            end
            S_G1: if (elapsed >= MIN_M1 && (sens2 | ped_req | night_req) &&
                      (!sens1 || elapsed >= MAX_M1))
                state_nx = S_Y1;
            S_G2: if (elapsed >= MIN_M1 && (sens1 | ped_req | night_req) &&
                      (!sens2 || elapsed >= MAX_M1))
                state_nx = S_Y2;
            S_Y1:    if (elapsed == YEL_M1)  state_nx = S_CLR;
            S_Y2:    if (elapsed == YEL_M1)  state_nx = S_CLR;
            S_WALK:  if (elapsed == WALK_M1) state_nx = S_CLR;
            S_FLASH: if (!night_req)         state_nx = S_CLR;
            default: state_nx = S_CLR;
        endcase
    end

    // Presses during WALK are dropped; FLASH holds the latch clear.
    assign ped_nx = (state == S_WALK || state == S_FLASH) ? 1'b0 : ped_req;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state       <= S_CLR;
            elapsed     <= '0;
            ptr         <= 2'd0;
            ped_pending <= 1'b0;
            via1        <= ROSSO;
            via2        <= ROSSO;
            walk        <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            ped_pending <= ped_nx;
            if (state_nx != state)
                elapsed <= '0;
            else if (elapsed != MAX_C)
                elapsed <= elapsed + 1'b1;
            // Lamps are registered from the next state so they track state.
            via1 <= ROSSO;
            via2 <= ROSSO;
            walk <= 1'b0;
            case (state_nx)
                S_G1:   via1 <= VERDE;
                S_Y1:   via1 <= GIALLO;
                S_G2:   via2 <= VERDE;
                S_Y2:   via2 <= GIALLO;
                S_WALK: walk <= 1'b1;
                S_FLASH: begin
                    // Enters on GIALLO, then alternates every clock.
                    via1 <= (state == S_FLASH && via1 == GIALLO) ? ROSSO : GIALLO;
                    via2 <= (state == S_FLASH && via1 == GIALLO) ? ROSSO : GIALLO;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_intersection_arbiter.sv
module tb_intersection_arbiter;
    logic       clock = 1'b0;
    logic       reset_ = 1'b0;
    logic       sens1 = 1'b0, sens2 = 1'b0, ped_btn = 1'b0, night = 1'b0;
    logic [1:0] via1, via2;
    logic       walk, ped_pending;
    logic [2:0] phase;
    int total = 0;
    int bad = 0;

    intersection_arbiter dut (
        .clock(clock), .reset_(reset_), .sens1(sens1), .sens2(sens2),
        .ped_btn(ped_btn), .night(night), .via1(via1), .via2(via2),
        .walk(walk), .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Holds reset across two edges, releases at posedge+1 (CLR cycle).
    task automatic do_reset();
        reset_ = 1'b0;
        step();
        step();
        reset_ = 1'b1;
    endtask

    task automatic test_reset();
        sens1 = 0; sens2 = 0; ped_btn = 0; night = 0;
        reset_ = 1'b0;
        step();
        step();
        total++;
        if (via1 !== 2'd0 || via2 !== 2'd0 || walk !== 1'b0 || ped_pending !== 1'b0 || phase !== 3'd0) begin
            bad++;
            $display("FAIL reset_state got v1=%0d v2=%0d w=%0d p=%0d ph=%0d exp all 0", via1, via2, walk, ped_pending, phase);
        end
        reset_ = 1'b1;
        total++;
        if (phase !== 3'd0) begin bad++; $display("FAIL reset_clr got ph=%0d exp 0", phase); end
        step();
        for (int i = 0; i < 55; i++) begin
            total++;
            if (phase !== 3'd1 || via1 !== 2'd2 || via2 !== 2'd0) begin
                bad++;
                $display("FAIL idle_g1 cyc=%0d got ph=%0d v1=%0d v2=%0d exp ph=1 v1=2 v2=0", i, phase, via1, via2);
            end
            step();
        end
    endtask

    task automatic test_min_green();
        int ph[4] = '{1, 2, 0, 3};
        int ln[4] = '{3, 2, 1, 2};
        int v1[4] = '{2, 1, 0, 0};
        int v2[4] = '{0, 0, 0, 2};
        sens1 = 0; sens2 = 0; ped_btn = 0; night = 0;
        do_reset();
        step();         // G1, elapsed 0
        step();         // G1, elapsed 1
        sens2 = 1'b1;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < ln[s]; i++) begin
                total++;
                if (phase !== 3'(ph[s]) || via1 !== 2'(v1[s]) || via2 !== 2'(v2[s])) begin
                    bad++;
                    $display("FAIL min_green s=%0d i=%0d got ph=%0d v1=%0d v2=%0d exp ph=%0d v1=%0d v2=%0d",
                             s, i, phase, via1, via2, ph[s], v1[s], v2[s]);
                end
                step();
            end
        sens2 = 1'b0;
    endtask

    task automatic test_alternate();
        int ph[6] = '{1, 2, 0, 3, 4, 0};
        int ln[6] = '{12, 2, 1, 12, 2, 1};
        int v1[6] = '{2, 1, 0, 0, 0, 0};
        int v2[6] = '{0, 0, 0, 2, 1, 0};
        sens1 = 1; sens2 = 1; ped_btn = 0; night = 0;
        do_reset();
        total++;
        if (phase !== 3'd0) begin bad++; $display("FAIL alt_clr got ph=%0d exp 0", phase); end
        step();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 6; s++)
                for (int i = 0; i < ln[s]; i++) begin
                    total++;
                    if (phase !== 3'(ph[s]) || via1 !== 2'(v1[s]) || via2 !== 2'(v2[s])) begin
                        bad++;
                        $display("FAIL alternate r=%0d s=%0d i=%0d got ph=%0d v1=%0d v2=%0d exp ph=%0d v1=%0d v2=%0d",
                                 r, s, i, phase, via1, via2, ph[s], v1[s], v2[s]);
                    end
                    step();
                end
        sens1 = 0; sens2 = 0;
    endtask

    task automatic test_ped();
        int ph[9] = '{1, 2, 0, 3, 4, 0, 5, 0, 3};
        int ln[9] = '{3, 2, 1, 12, 2, 1, 6, 1, 3};
        int v1[9] = '{2, 1, 0, 0, 0, 0, 0, 0, 0};
        int v2[9] = '{0, 0, 0, 2, 1, 0, 0, 0, 2};
        logic ep;
        sens1 = 0; sens2 = 0; ped_btn = 0; night = 0;
        do_reset();
        step();                         // G1, elapsed 0
        sens2 = 1'b1;
        ped_btn = 1'b1;
        step();                         // G1, elapsed 1
        ped_btn = 1'b0;
        total++;
        if (ped_pending !== 1'b1) begin bad++; $display("FAIL ped_latch got %0d exp 1", ped_pending); end
        for (int s = 0; s < 9; s++)
            for (int i = 0; i < ln[s]; i++) begin
                ep = (s < 6) || (s == 6 && i == 0);
                total++;
                if (phase !== 3'(ph[s]) || via1 !== 2'(v1[s]) || via2 !== 2'(v2[s]) ||
                    walk !== (s == 6) || ped_pending !== ep) begin
                    bad++;
                    $display("FAIL ped_seq s=%0d i=%0d got ph=%0d v1=%0d v2=%0d w=%0d p=%0d exp ph=%0d v1=%0d v2=%0d w=%0d p=%0d",
                             s, i, phase, via1, via2, walk, ped_pending, ph[s], v1[s], v2[s], (s == 6), ep);
                end
                step();
            end
        sens2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        sens1 = 0; sens2 = 1; ped_btn = 0; night = 0;
        do_reset();
        step();
        total++;
        if (phase !== 3'd3) begin bad++; $display("FAIL mid_g2 got ph=%0d exp 3", phase); end
        sens2 = 1'b0;
        ped_btn = 1'b1;
        step();
        ped_btn = 1'b0;
        for (int i = 0; i < 10 && phase !== 3'd4; i++) step();
        total++;
        if (phase !== 3'd4 || via2 !== 2'd1 || ped_pending !== 1'b1) begin
            bad++;
            $display("FAIL mid_y2 got ph=%0d v2=%0d p=%0d exp ph=4 v2=1 p=1", phase, via2, ped_pending);
        end
        #3 reset_ = 1'b0;
        #1;
        total++;
        if (phase !== 3'd0 || via2 !== 2'd0 || ped_pending !== 1'b0) begin
            bad++;
            $display("FAIL mid_async got ph=%0d v2=%0d p=%0d exp 0 0 0", phase, via2, ped_pending);
        end
        #1 reset_ = 1'b1;
        step();
        total++;
        if (phase !== 3'd1 || via1 !== 2'd2) begin
            bad++;
            $display("FAIL mid_restart got ph=%0d v1=%0d exp ph=1 v1=2", phase, via1);
        end
    endtask

`ifdef NIGHT_FLASH_EN
    task automatic test_night();
        sens1 = 0; sens2 = 1; ped_btn = 0; night = 0;
        do_reset();
        step();                         // G2
        night = 1'b1;
        sens2 = 1'b0;
        for (int i = 0; i < 30 && phase !== 3'd6; i++) step();
        for (int i = 0; i < 6; i++) begin
            ped_btn = (i >= 2);
            total++;
            if (phase !== 3'd6 || via1 !== ((i % 2) == 0 ? 2'd1 : 2'd0) ||
                via2 !== ((i % 2) == 0 ? 2'd1 : 2'd0) || walk !== 1'b0 || ped_pending !== 1'b0) begin
                bad++;
                $display("FAIL flash i=%0d got ph=%0d v1=%0d v2=%0d w=%0d p=%0d exp ph=6 v=%0d w=0 p=0",
                         i, phase, via1, via2, walk, ped_pending, (i % 2) == 0);
            end
            step();
        end
        ped_btn = 1'b0;
        night = 1'b0;
        step();
        total++;
        if (phase !== 3'd0 || ped_pending !== 1'b0) begin
            bad++;
            $display("FAIL flash_exit got ph=%0d p=%0d exp 0 0", phase, ped_pending);
        end
        step();
        total++;
        if (phase !== 3'd1) begin bad++; $display("FAIL flash_rearb got ph=%0d exp 1", phase); end
    endtask
`else
    task automatic test_night();
        sens1 = 0; sens2 = 0; ped_btn = 0; night = 0;
        do_reset();
        step();
        night = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (phase !== 3'd1 || via1 !== 2'd2) begin
                bad++;
                $display("FAIL night_ignored i=%0d got ph=%0d v1=%0d exp ph=1 v1=2", i, phase, via1);
            end
        end
        night = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_min_green();
        test_alternate();
        test_ped();
        test_reset_mid();
        test_night();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
